// File: rtl/bcd_to_binary.sv
// 4-digit BCD to 14-bit binary converter, reverse double-dabble (shift, -3).
// Define BCD_CHECK_EN to reject inputs with a nibble above 9 via `error`.
module bcd_to_binary (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bcd_in,
  output logic        busy,
  output logic        done,
  output logic [13:0] binary_out,
  output logic        error
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [29:0] w_q, w_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [13:0] bin_q, bin_d;
  logic [29:0] sh;
  logic [3:0]  nib;

`ifdef BCD_CHECK_EN
  logic chk_q, chk_d;
  logic err_q, err_d;
  logic bad_in;

  assign bad_in = (bcd_in[15:12] > 4'd9) | (bcd_in[11:8] > 4'd9)
                | (bcd_in[7:4] > 4'd9) | (bcd_in[3:0] > 4'd9);
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign busy       = (state_q == SHIFT);
  assign done       = done_q;
  assign binary_out = bin_q;

  // Correction is applied to the post-shift BCD nibbles.
  always_comb begin
    sh  = w_q >> 1;
    nib = '0;
    for (int i = 0; i < 4; i++) begin
      nib = sh[14 + 4*i +: 4];
      if (nib >= 4'd8) sh[14 + 4*i +: 4] = nib - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
`ifdef BCD_CHECK_EN
    chk_d   = chk_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
`ifdef BCD_CHECK_EN
          chk_d   = bad_in;
          if (!bad_in) w_d = {bcd_in, 14'b0};
`else
          w_d     = {bcd_in, 14'b0};
`endif
        end
      end
      SHIFT: begin
`ifdef BCD_CHECK_EN
        if (chk_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bin_d   = '0;
          err_d   = 1'b1;
          chk_d   = 1'b0;
        end else begin
`else
        begin
`endif
          w_d   = sh;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            state_d = IDLE;
            done_d  = 1'b1;
            bin_d   = sh[13:0];
`ifdef BCD_CHECK_EN
            err_d   = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      bin_q   <= '0;
`ifdef BCD_CHECK_EN
      chk_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
`ifdef BCD_CHECK_EN
      chk_q   <= chk_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
